lcd_frame_sequencer: RTL and testbench

Sequencer for the 2x16 character text LCD. After a synchronous reset it runs the controller power-up and initialisation command sequence. On request, or continuously when auto-refresh is enabled, it writes a snapshot of a 32-character frame buffer to both display lines. It sits between the display-memory logic (the `data` bus plus a request/ack handshake) and the LCD pins, and owns all RS/RW/EN/DATA timing.

---
 rtl/lcd_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: 2x16 text LCD power-up/init sequencer and frame-buffer writer.
module lcd_frame_sequencer #(
    parameter int T_PWR        = 30000,
    parameter int T_SETUP      = 200,
    parameter int T_EN         = 1600,
    parameter int T_CYCLE      = 2000,
    parameter int T_LONG       = 4000,
    parameter bit AUTO_REFRESH = 1'b0
) (
    input  logic         LCDCLK,
    input  logic         PRESET,
    input  logic [255:0] data,
    input  logic         update_req,
    output logic         update_ack,
    output logic         busy,
    output logic         init_done,
    output logic         frame_done,
    output logic         LCD_RS,
    output logic         LCD_RW,
    output logic         LCD_EN,
    output logic [7:0]   LCD_DATA
);
    localparam int MAX_A = T_PWR > T_LONG ? T_PWR : T_LONG;
    localparam int MAX_T = MAX_A > T_CYCLE ? MAX_A : T_CYCLE;
    localparam int CW    = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [4:0]     idx, idx_n;
    logic           lwait, lwait_n, pend, pend_n, accept, tend, xfer_n, start_n;
    logic           ack_n, done_n, init_n, en_n, rs_n;
    logic [7:0]     byte_n, data_n;
    logic [255:0]   frame;

    assign LCD_RW = 1'b0;
    assign tend   = cnt == CW'(T_CYCLE - 1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        lwait_n = lwait;
        pend_n  = pend | update_req;
        accept  = 1'b0;
        done_n  = 1'b0;
        init_n  = init_done;
        case (state)
            PWR_WAIT: if (cnt == CW'(T_PWR - 1)) begin
                state_n = INIT;
                cnt_n   = '0;
            end
            INIT: if (lwait) begin
                if (cnt == CW'(T_LONG - 1)) begin
                    cnt_n   = '0;
                    lwait_n = 1'b0;
                    idx_n   = idx + 5'd1;
                    if (idx == 5'd4) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        init_n  = 1'b1;
                    end
                end
            end else if (tend) begin
                // 0x02 and 0x01 (steps 3 and 4) need the long settle time
                cnt_n = '0;
                if (idx == 5'd3 || idx == 5'd4) lwait_n = 1'b1;
                else idx_n = idx + 5'd1;
            end
            IDLE: begin
                cnt_n = '0;
                if (update_req || AUTO_REFRESH || pend) begin
                    state_n = L1_ADDR;
                    accept  = 1'b1;
                    pend_n  = 1'b0;
                end
            end
            L1_ADDR: if (tend) begin
                cnt_n   = '0;
                state_n = L1_CHAR;
            end
            L1_CHAR: if (tend) begin
                cnt_n   = '0;
                idx_n   = idx + 5'd1;
                state_n = idx == 5'd15 ? L2_ADDR : L1_CHAR;
            end
            L2_ADDR: if (tend) begin
                cnt_n   = '0;
                state_n = L2_CHAR;
            end
            L2_CHAR: if (tend) begin
                cnt_n = '0;
                idx_n = idx + 5'd1;
                if (idx == 5'd31) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = PWR_WAIT;
        endcase
        ack_n   = accept;
        xfer_n  = (state_n == INIT && !lwait_n) || state_n inside {L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR};
        start_n = xfer_n && cnt_n == '0;
        en_n    = xfer_n && cnt_n >= CW'(T_SETUP) && cnt_n < CW'(T_SETUP + T_EN);
        rs_n    = state_n inside {L1_CHAR, L2_CHAR};
        byte_n  = state_n == INIT    ? (idx_n == 5'd0 ? 8'h38 : idx_n == 5'd1 ? 8'h0E :
                                        idx_n == 5'd2 ? 8'h06 : idx_n == 5'd3 ? 8'h02 : 8'h01) :
                  state_n == L1_ADDR ? 8'h80 :
                  state_n == L2_ADDR ? 8'hC0 : frame[{idx_n, 3'b000} +: 8];
        data_n  = start_n ? byte_n : LCD_DATA;
    end

    always_ff @(posedge LCDCLK) begin
        if (PRESET) begin
            state      <= PWR_WAIT;
            cnt        <= '0;
            idx        <= '0;
            lwait      <= 1'b0;
            pend       <= 1'b0;
            update_ack <= 1'b0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_EN     <= 1'b0;
            LCD_DATA   <= 8'h00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            lwait      <= lwait_n;
            pend       <= pend_n;
            update_ack <= ack_n;
            busy       <= state_n != IDLE;
            init_done  <= init_n;
            frame_done <= done_n;
            LCD_RS     <= start_n ? rs_n : LCD_RS;
            LCD_EN     <= en_n;
            LCD_DATA   <= data_n;
        end
    end

    always_ff @(posedge LCDCLK) begin
        if (accept) frame <= data;
    end
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: directed/random checks of init, frame writes, pending and auto-refresh.
module tb_lcd_frame_sequencer;
    localparam int T_PWR = 10, T_SETUP = 2, T_EN = 4, T_CYCLE = 8, T_LONG = 16;
    localparam int FRAME_LEN = 34 * T_CYCLE;
    localparam int INIT_LEN  = T_PWR + 5 * T_CYCLE + 2 * T_LONG;

    logic         clk = 1'b0, rst = 1'b1, req = 1'b0;
    logic [255:0] data = '0;
    logic         ack, busy, init_done, frame_done, rs, rw, en;
    logic [7:0]   lcd_data;
    logic         ar_ack, ar_busy, ar_init, ar_done, ar_rs, ar_rw, ar_en;
    logic [7:0]   ar_data;

    int n_asserts = 0, n_fails = 0, t = 0;
    logic en_q = 1'b0;
    logic [7:0] sq_d[$];
    logic       sq_rs[$];
    int         sq_t[$], sq_w[$], ack_q[$], done_q[$], ar_ack_q[$], ar_done_q[$];
    logic [7:0] ar_ack_d[$];
    logic [7:0] init_cmds [5] = '{8'h38, 8'h0E, 8'h06, 8'h02, 8'h01};

    lcd_frame_sequencer #(.T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_CYCLE(T_CYCLE),
                          .T_LONG(T_LONG), .AUTO_REFRESH(1'b0)) dut (
        .LCDCLK(clk), .PRESET(rst), .data(data), .update_req(req), .update_ack(ack),
        .busy(busy), .init_done(init_done), .frame_done(frame_done), .LCD_RS(rs),
        .LCD_RW(rw), .LCD_EN(en), .LCD_DATA(lcd_data));

    lcd_frame_sequencer #(.T_PWR(T_PWR), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_CYCLE(T_CYCLE),
                          .T_LONG(T_LONG), .AUTO_REFRESH(1'b1)) dut_ar (
        .LCDCLK(clk), .PRESET(rst), .data(data), .update_req(1'b0), .update_ack(ar_ack),
        .busy(ar_busy), .init_done(ar_init), .frame_done(ar_done), .LCD_RS(ar_rs),
        .LCD_RW(ar_rw), .LCD_EN(ar_en), .LCD_DATA(ar_data));

    always #5 clk = ~clk;

    // cycle index relative to the last edge that saw reset asserted
    always @(posedge clk) t <= rst ? 0 : t + 1;

    always @(negedge clk) begin
        if (en && !en_q) begin
            sq_d.push_back(lcd_data);
            sq_rs.push_back(rs);
            sq_t.push_back(t);
            sq_w.push_back(0);
        end
        if (!en && en_q && sq_w.size() > 0) sq_w[sq_w.size()-1] = t - sq_t[sq_t.size()-1];
        if (ack) ack_q.push_back(t);
        if (frame_done) done_q.push_back(t);
        if (ar_ack) begin
            ar_ack_q.push_back(t);
            ar_ack_d.push_back(ar_data);
        end
        if (ar_done) ar_done_q.push_back(t);
        en_q = en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_queues();
        sq_d.delete(); sq_rs.delete(); sq_t.delete(); sq_w.delete();
        ack_q.delete(); done_q.delete();
        ar_ack_q.delete(); ar_ack_d.delete(); ar_done_q.delete();
    endtask

    function automatic logic [255:0] rand_frame();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_init();
        for (int i = 0; i < 4 * INIT_LEN && init_done !== 1'b1; i++) tick();
        check("init_done_rise", init_done, 1);
        check("init_done_cycle", t, INIT_LEN);
    endtask

    task automatic wait_done(output int td);
        for (int i = 0; i < 2 * FRAME_LEN && frame_done !== 1'b1; i++) tick();
        check("frame_done_seen", frame_done, 1);
        td = t;
    endtask

    task automatic check_init();
        check("init_strobe_count", sq_d.size(), 5);
        if (sq_d.size() >= 5)
            for (int k = 0; k < 5; k++) begin
                check($sformatf("init_byte%0d", k), sq_d[k], init_cmds[k]);
                check($sformatf("init_rs%0d", k), sq_rs[k], 0);
                check($sformatf("init_rise%0d", k), sq_t[k],
                      T_PWR + k * T_CYCLE + (k == 4 ? T_LONG : 0) + T_SETUP);
                check($sformatf("init_width%0d", k), sq_w[k], T_EN);
            end
    endtask

    // expected strobe stream: 0x80, chars 0..15, 0xC0, chars 16..31
    task automatic check_frame(input logic [255:0] snap, input int base, input int ta);
        logic [7:0] e;
        int ones;
        ones = 0;
        check("frame_strobes_present", sq_d.size() >= base + 34, 1);
        if (sq_d.size() >= base + 34) begin
            for (int k = 0; k < 34; k++) begin
                e = k == 0 ? 8'h80 : k == 17 ? 8'hC0 : snap[8 * (k < 17 ? k - 1 : k - 2) +: 8];
                check($sformatf("frame_byte%0d", k), sq_d[base+k], e);
                check($sformatf("frame_rs%0d", k), sq_rs[base+k], (k != 0 && k != 17) ? 1 : 0);
                check($sformatf("frame_rise%0d", k), sq_t[base+k], ta + k * T_CYCLE + T_SETUP);
                check($sformatf("frame_width%0d", k), sq_w[base+k], T_EN);
                ones += sq_rs[base+k] ? 1 : 0;
            end
            check("frame_rs_count", ones, 32);
        end
    endtask

    initial begin
        logic [255:0] d1, d2, d3, d4, hello;
        string s;
        int ta, ta2, td, td2;
        s = "HELLO WORLD";
        for (int i = 0; i < 32; i++) hello[8*i +: 8] = i < s.len() ? s[i] : 8'h20;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_en", en, 0);
        check("rst_data", lcd_data, 0);
        check("rst_rs", rs, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        check("rst_ack", ack, 0);
        check("rst_frame_done", frame_done, 0);
        clear_queues();
        wait_init();
        check_init();
        check("idle_busy", busy, 0);

        clear_queues();
        data = hello;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        ta = t;
        check("ack_latency", ack, 1);
        check("ack_busy", busy, 1);
        check("ack_data", lcd_data, 8'h80);
        check("ack_rs", rs, 0);
        tick();
        check("ack_one_cycle", ack, 0);
        data = {32{8'h41}};
        wait_done(td);
        check("frame_length", td - ta, FRAME_LEN);
        check("done_not_busy", busy, 0);
        tick();
        check("done_one_cycle", frame_done, 0);
        check_frame(hello, 0, ta);

        clear_queues();
        d1 = rand_frame();
        d2 = rand_frame();
        data = d1;
        req = 1'b1;
        tick();
        req = 1'b0;
        ta = t;
        tick();
        data = d2;
        repeat (20) tick();
        req = 1'b1; tick(); req = 1'b0;
        repeat (30) tick();
        req = 1'b1; tick(); req = 1'b0;
        repeat (50) tick();
        req = 1'b1; tick(); req = 1'b0;
        wait_done(td);
        check("pend_frame1_len", td - ta, FRAME_LEN);
        tick();
        ta2 = t;
        check("pend_ack", ack, 1);
        check("pend_ack_data", lcd_data, 8'h80);
        wait_done(td2);
        check("pend_frame2_len", td2 - ta2, FRAME_LEN);
        repeat (2 * FRAME_LEN) tick();
        check("pend_ack_count", ack_q.size(), 2);
        check("pend_done_count", done_q.size(), 2);
        check_frame(d1, 0, ta);
        check_frame(d2, 34, ta2);

        clear_queues();
        d3 = rand_frame();
        data = d3;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN && !(sq_d.size() == 23 && en === 1'b1); i++) tick();
        check("char20_strobe", sq_d.size() == 23 && en === 1'b1, 1);
        if (sq_d.size() == 23) check("char20_byte", sq_d[22], d3[8*20 +: 8]);
        rst = 1'b1;
        tick();
        check("midrst_en", en, 0);
        check("midrst_data", lcd_data, 0);
        check("midrst_busy", busy, 1);
        check("midrst_init_done", init_done, 0);
        check("midrst_rs", rs, 0);
        check("midrst_ack", ack, 0);
        rst = 1'b0;
        clear_queues();
        d4 = rand_frame();
        data = d4;
        repeat (3) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_init();
        check_init();
        tick();
        check("init_pend_ack", ack, 1);
        check("init_pend_ack_cycle", t, INIT_LEN + 1);
        check("init_pend_data", lcd_data, 8'h80);
        wait_done(td);
        check("init_pend_len", td - (INIT_LEN + 1), FRAME_LEN);
        check_frame(d4, 5, INIT_LEN + 1);

        repeat (3 * FRAME_LEN) tick();
        check("ar_frames", ar_ack_q.size() >= 3, 1);
        if (ar_ack_q.size() >= 1) check("ar_first_ack", ar_ack_q[0], INIT_LEN + 1);
        for (int k = 0; k < ar_ack_q.size() && k < ar_done_q.size(); k++) begin
            check($sformatf("ar_start_data%0d", k), ar_ack_d[k], 8'h80);
            check($sformatf("ar_len%0d", k), ar_done_q[k] - ar_ack_q[k], FRAME_LEN);
            if (k + 1 < ar_ack_q.size())
                check($sformatf("ar_restart%0d", k), ar_ack_q[k+1], ar_done_q[k] + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
